// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
//   fwd_sel_e    : EX operand source select (register file, MEM/WB data, EX/MEM result)
//   stage_info_t : register-usage shadow of one pipeline stage (EX, MEM or WB)
//   writes_reg() : true when a stage entry produces a non-x0 value for a given register
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  reg_write;
        logic                  mem_read;
        logic                  is_branch;
    } stage_info_t;

    // x0 is hard-wired zero, so a write to it never feeds anybody.
    function automatic logic writes_reg(input stage_info_t entry,
                                        input logic [REG_ADDR_W-1:0] idx);
        return entry.valid & entry.reg_write &
               (entry.rd != {REG_ADDR_W{1'b0}}) & (entry.rd == idx);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX ALU operand.
//   src      : source register index of the instruction in EX
//   uses     : the EX instruction actually reads src
//   mem_info : shadow entry of the MEM stage
//   wb_info  : shadow entry of the WB stage
//   sel      : FWD_MEM beats FWD_WB beats FWD_RF
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  uses,
    input  stage_info_t           mem_info,
    input  stage_info_t           wb_info,
    output fwd_sel_e              sel
);

    // Fields of the stage entries that play no part in operand selection.
    logic unused_fields_s;
    assign unused_fields_s = ^{mem_info.rs1, mem_info.rs2, mem_info.uses_rs1,
                               mem_info.uses_rs2, mem_info.is_branch,
                               wb_info.rs1, wb_info.rs2, wb_info.uses_rs1,
                               wb_info.uses_rs2, wb_info.mem_read, wb_info.is_branch};

    // Priority select; a load in MEM has no data yet, so it is never a forward source.
    always_comb begin
        sel = FWD_RF;
        if (uses && writes_reg(mem_info, src) && !mem_info.mem_read) begin
            sel = FWD_MEM;
        end else if (uses && writes_reg(wb_info, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline.
// Keeps registered shadows of EX/MEM/WB register usage and derives:
//   pc_write, ifid_write    : PC and IF/ID load enables (low during a load-use stall)
//   ifid_flush, pc_src      : taken-branch redirect and IF/ID kill
//   idex_bubble             : zero the ID/EX control fields
//   fwd_a, fwd_b            : EX operand forwarding selects
//   id_byp_a, id_byp_b      : WB write data bypass into the ID register-file read
//   stall_cnt, flush_cnt    : saturating debug event counters
// Inputs are the ID-stage decode fields, id_valid and ex_branch_taken.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_branch,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pc_src,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  id_byp_a,
    output logic                  id_byp_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    stage_info_t ex_r;
    stage_info_t mem_r;
    stage_info_t wb_r;
    stage_info_t id_entry_s;

    logic     take_s;
    logic     load_use_s;
    logic     stall_s;
    fwd_sel_e fwd_a_sel_s;
    fwd_sel_e fwd_b_sel_s;

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // WB fields not consulted for the ID bypass or by the forwarding selects' ports.
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_r.rs1, wb_r.rs2, wb_r.uses_rs1, wb_r.uses_rs2,
                           wb_r.mem_read, wb_r.is_branch};

    // A taken indication only counts when a real branch sits in EX.
    always_comb begin
        take_s = ex_branch_taken & ex_r.valid & ex_r.is_branch;
    end

    // Load in EX whose destination the ID instruction reads.
    always_comb begin
        load_use_s = 1'b0;
        if (id_valid && ex_r.valid && ex_r.mem_read && (ex_r.rd != {REG_ADDR_W{1'b0}})) begin
            load_use_s = (id_uses_rs1 && (id_rs1 == ex_r.rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_r.rd));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Sequencing outputs; the branch redirect overrides the stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_src      = 1'b0;
        stall_s     = 1'b0;
        if (take_s) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_s     = 1'b1;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
        end
    end

    // Entry that moves into EX on the next edge; a bubble enters as all-zero.
    always_comb begin
        id_entry_s = '0;
        if (id_valid && !idex_bubble) begin
            id_entry_s.valid     = 1'b1;
            id_entry_s.rd        = id_rd;
            id_entry_s.rs1       = id_rs1;
            id_entry_s.rs2       = id_rs2;
            id_entry_s.uses_rs1  = id_uses_rs1;
            id_entry_s.uses_rs2  = id_uses_rs2;
            id_entry_s.reg_write = id_reg_write;
            id_entry_s.mem_read  = id_mem_read;
            id_entry_s.is_branch = id_is_branch;
        end else begin
            id_entry_s = '0;
        end
    end

    // Shadow pipeline advance: WB <- MEM <- EX <- ID every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            ex_r  <= id_entry_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Saturating debug counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (take_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    fwd_select u_fwd_a (
        .src      (ex_r.rs1),
        .uses     (ex_r.uses_rs1),
        .mem_info (mem_r),
        .wb_info  (wb_r),
        .sel      (fwd_a_sel_s)
    );

    fwd_select u_fwd_b (
        .src      (ex_r.rs2),
        .uses     (ex_r.uses_rs2),
        .mem_info (mem_r),
        .wb_info  (wb_r),
        .sel      (fwd_b_sel_s)
    );

    assign fwd_a = fwd_a_sel_s;
    assign fwd_b = fwd_b_sel_s;

    // Register file is written in WB; hand the same-cycle write data to the ID read.
    always_comb begin
        id_byp_a = id_uses_rs1 & writes_reg(wb_r, id_rs1);
        id_byp_b = id_uses_rs2 & writes_reg(wb_r, id_rs2);
    end

endmodule
